// File: rtl/fpga_pll_drp_ctrl.sv
// MMCM runtime reconfiguration sequencer: reset, DRP read-modify-write per preset entry, relock.
// Define PLL_DRP_READBACK_EN to verify each written word with a DRP read-back.
module fpga_pll_drp_ctrl #(
   parameter int N_ENTRIES = 23,
   parameter int SEL_W     = 2,
   parameter int RST_HOLD  = 8,
   parameter int DRDY_TMO  = 63,
   parameter int LOCK_TMO  = 65535,
   localparam int IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             cfg_req,
   input  logic [SEL_W-1:0] cfg_sel,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [SEL_W-1:0] tbl_sel,
   output logic [IDX_W-1:0] tbl_idx,
   input  logic [6:0]       tbl_addr,
   input  logic [15:0]      tbl_mask,
   input  logic [15:0]      tbl_data,
   output logic             mmcm_rst,
   input  logic             pll_lock,
   output logic             drp_den,
   output logic             drp_dwe,
   output logic [6:0]       drp_daddr,
   output logic [15:0]      drp_di,
   input  logic [15:0]      drp_do,
   input  logic             drp_drdy
);

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int DRDY_W = $clog2(DRDY_TMO + 1);
   localparam int LOCK_W = $clog2(LOCK_TMO + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [DRDY_W-1:0] DRDY_MAX  = DRDY_W'(DRDY_TMO);
   localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_TMO);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_ENTRIES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST_PRE,
      S_RD,
      S_RD_WAIT,
      S_WR,
      S_WR_WAIT,
`ifdef PLL_DRP_READBACK_EN
      S_VFY,
      S_VFY_WAIT,
`endif
      S_NEXT,
      S_RST_POST,
      S_LOCK_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic                lock_meta, lock_s;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [DRDY_W-1:0]   drdy_cnt;
   logic [LOCK_W-1:0]   lock_cnt;
   logic                last_q;
   logic                rst_d, den_d;
   logic [15:0]         merged;

   assign merged = (drp_do & tbl_mask) | (tbl_data & ~tbl_mask);

   always_ff @(posedge clk) begin
      if (srst) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_lock;
         lock_s    <= lock_meta;
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (cfg_req) state_d = S_RST_PRE;
         S_RST_PRE:   if (hold_cnt == HOLD_LAST) state_d = S_RD;
         S_RD:        state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (drp_drdy)                  state_d = S_WR;
            else if (drdy_cnt == DRDY_MAX) state_d = S_ERR;
         end
         S_WR:        state_d = S_WR_WAIT;
         S_WR_WAIT: begin
`ifdef PLL_DRP_READBACK_EN
            if (drp_drdy)                  state_d = S_VFY;
`else
            if (drp_drdy)                  state_d = S_NEXT;
`endif
            else if (drdy_cnt == DRDY_MAX) state_d = S_ERR;
         end
`ifdef PLL_DRP_READBACK_EN
         S_VFY:       state_d = S_VFY_WAIT;
         S_VFY_WAIT: begin
            if (drp_drdy)                  state_d = (drp_do == drp_di) ? S_NEXT : S_ERR;
            else if (drdy_cnt == DRDY_MAX) state_d = S_ERR;
         end
`endif
         S_NEXT:      state_d = last_q ? S_RST_POST : S_RD;
         S_RST_POST:  if (hold_cnt == HOLD_LAST) state_d = S_LOCK_WAIT;
         S_LOCK_WAIT: begin
            if (lock_s)                    state_d = S_DONE;
            else if (lock_cnt == LOCK_MAX) state_d = S_ERR;
         end
         S_DONE:      state_d = S_IDLE;
         S_ERR:       state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase

      rst_d = !(state_d inside {S_IDLE, S_LOCK_WAIT, S_DONE, S_ERR});
      den_d = (state_d == S_RD) || (state_d == S_WR);
`ifdef PLL_DRP_READBACK_EN
      if (state_d == S_VFY) den_d = 1'b1;
`endif
   end

   // All counters restart on every state change and saturate at their limit.
   always_ff @(posedge clk) begin
      if (srst || (state_d != state_q)) begin
         hold_cnt <= '0;
         drdy_cnt <= '0;
         lock_cnt <= '0;
      end else begin
         if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HOLD_W'(1);
         if (drdy_cnt != DRDY_MAX)  drdy_cnt <= drdy_cnt + DRDY_W'(1);
         if (lock_cnt != LOCK_MAX)  lock_cnt <= lock_cnt + LOCK_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q   <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mmcm_rst  <= 1'b0;
         drp_den   <= 1'b0;
         drp_dwe   <= 1'b0;
         drp_daddr <= '0;
         drp_di    <= '0;
         tbl_sel   <= '0;
         tbl_idx   <= '0;
         last_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy     <= (state_d != S_IDLE);
         done     <= (state_d == S_DONE);
         mmcm_rst <= rst_d;
         drp_den  <= den_d;
         drp_dwe  <= (state_d == S_WR);

         if (state_q == S_IDLE && cfg_req) begin
            tbl_sel <= cfg_sel;
            tbl_idx <= '0;
            last_q  <= 1'b0;
            err     <= 1'b0;
         end else if (state_d == S_ERR) begin
            err <= 1'b1;
         end

         if (state_d == S_RD) drp_daddr <= tbl_addr;
         if (state_q == S_RD_WAIT && drp_drdy) drp_di <= merged;

         // The index advances on entry to NEXT so the table address has settled before RD latches it.
         if (state_d == S_NEXT) begin
            if (tbl_idx == IDX_LAST) last_q <= 1'b1;
            else                     tbl_idx <= tbl_idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fpga_pll_drp_ctrl.sv
// Scoreboard bench for fpga_pll_drp_ctrl: DRP slave model, MMCM lock model, expected-write queue.
module tb_fpga_pll_drp_ctrl;

   localparam int N_ENTRIES = 3;
   localparam int SEL_W     = 2;
   localparam int RST_HOLD  = 8;
   localparam int DRDY_TMO  = 63;
   localparam int LOCK_TMO  = 100;
   localparam int IDX_W     = 2;
`ifdef PLL_DRP_READBACK_EN
   localparam int PER_ENTRY = 7;
`else
   localparam int PER_ENTRY = 5;
`endif
   localparam logic [15:0] MASK = 16'hFF00;
   localparam logic [15:0] DATA = 16'h1234;

   typedef struct {
      logic [6:0]  addr;
      logic [15:0] data;
   } wr_t;

   logic             clk = 1'b0;
   logic             srst = 1'b1;
   logic             cfg_req = 1'b0;
   logic [SEL_W-1:0] cfg_sel = '0;
   logic             busy, done, err, mmcm_rst;
   logic [SEL_W-1:0] tbl_sel;
   logic [IDX_W-1:0] tbl_idx;
   logic [6:0]       tbl_addr;
   logic             pll_lock = 1'b0;
   logic             drp_den, drp_dwe;
   logic [6:0]       drp_daddr;
   logic [15:0]      drp_di;
   logic [15:0]      drp_do = '0;
   logic             drp_drdy = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   // Test-control knobs, written only by the main sequence.
   int         gen = 1;
   int         drdy_dly = 2;
   int         drop_read = 0;
   bit         corrupt_en = 1'b0;
   logic [6:0] corrupt_addr = '0;
   bit         lock_en = 1'b1;

   // Model state, written only by the model processes.
   wr_t         exp_q[$];
   int          wr_cyc[$];
   int          rd_cyc[$];
   logic [15:0] mem [128];
   int          wgen [128];
   int          mgen = 0;
   int          rd_n = 0;
   int          pend = 0;
   logic [15:0] resp = '0;
   logic        den_prev = 1'b0;
   int          lk = 0;

   assign tbl_addr = {tbl_sel, 3'b000, tbl_idx};

   fpga_pll_drp_ctrl #(
      .N_ENTRIES(N_ENTRIES), .SEL_W(SEL_W), .RST_HOLD(RST_HOLD),
      .DRDY_TMO(DRDY_TMO), .LOCK_TMO(LOCK_TMO)
   ) dut (
      .clk(clk), .srst(srst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
      .busy(busy), .done(done), .err(err),
      .tbl_sel(tbl_sel), .tbl_idx(tbl_idx),
      .tbl_addr(tbl_addr), .tbl_mask(MASK), .tbl_data(DATA),
      .mmcm_rst(mmcm_rst), .pll_lock(pll_lock),
      .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr),
      .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] merge(input logic [15:0] rd);
      return (rd & MASK) | (DATA & ~MASK);
   endfunction

   function automatic logic [6:0] entry_addr(input logic [SEL_W-1:0] sel, input int idx);
      return {sel, 3'b000, 2'(idx)};
   endfunction

   // DRP slave: answers drdy_dly cycles after each den, checks writes against the scoreboard.
   always @(negedge clk) begin
      if (mgen != gen) begin
         mgen = gen;
         rd_n = 0;
         pend = 0;
         wr_cyc.delete();
         rd_cyc.delete();
      end
      drp_drdy = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            drp_drdy = 1'b1;
            drp_do   = resp;
         end
      end
      if (drp_den) begin
         check("den_one_cycle", den_prev, 0);
         if (drp_dwe) begin
            mem[drp_daddr]  = drp_di;
            wgen[drp_daddr] = gen;
            wr_cyc.push_back(cyc);
            check("wr_under_rst", mmcm_rst, 1);
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", drp_daddr, e.addr);
               check("wr_data", drp_di, e.data);
            end
            resp = 16'h0000;
            pend = drdy_dly;
         end else begin
            rd_n++;
            rd_cyc.push_back(cyc);
            resp = (wgen[drp_daddr] == gen) ? mem[drp_daddr] : 16'hFFFF;
            if (corrupt_en && drp_daddr == corrupt_addr && wgen[drp_daddr] == gen)
               resp[0] = ~resp[0];
            pend = (rd_n == drop_read) ? 0 : drdy_dly;
         end
      end
      den_prev = drp_den;
   end

   // MMCM: lock drops in reset and returns six cycles after release when enabled.
   always @(negedge clk) begin
      if (mmcm_rst) begin
         pll_lock = 1'b0;
         lk = 0;
      end else if (lk < 6) begin
         lk++;
      end else begin
         pll_lock = lock_en;
      end
   end

   task automatic push_writes(input logic [SEL_W-1:0] sel, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{addr: entry_addr(sel, i), data: merge(16'hFFFF)});
   endtask

   task automatic start(input logic [SEL_W-1:0] sel);
      @(negedge clk);
      cfg_sel = sel;
      cfg_req = 1'b1;
      @(negedge clk);
      cfg_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(tag, busy, 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ctl"}, {busy, done, err, mmcm_rst, drp_den, drp_dwe}, 0);
      check({tag, "_daddr"}, drp_daddr, 0);
      check({tag, "_di"}, drp_di, 0);
      check({tag, "_idx"}, tbl_idx, 0);
      check({tag, "_sel"}, tbl_sel, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, n, c_err;
      bit prev;

      repeat (3) @(negedge clk);
      check_reset("por");
      srst = 1'b0;
      repeat (2) @(negedge clk);

      // Nominal sequence on preset 1.
      gen++;
      drdy_dly = 2;
      push_writes(2'd1, N_ENTRIES);
      d0 = done_cnt;
      start(2'd1);
      check("nom_busy", busy, 1);
      wait_idle("nom_idle");
      check("nom_done_pulses", done_cnt - d0, 1);
      check("nom_err", err, 0);
      check("nom_rst_off", mmcm_rst, 0);
      check("nom_q_empty", exp_q.size(), 0);

      // cfg_req while busy is ignored; also per-entry cost with immediate DRDY.
      gen++;
      drdy_dly = 1;
      push_writes(2'd2, N_ENTRIES);
      d0 = done_cnt;
      start(2'd2);
      repeat (12) @(negedge clk);
      cfg_sel = 2'd3;
      cfg_req = 1'b1;
      @(negedge clk);
      cfg_req = 1'b0;
      check("busy_req_sel", tbl_sel, 2);
      wait_idle("busy_req_idle");
      check("busy_req_sel_end", tbl_sel, 2);
      check("busy_req_done", done_cnt - d0, 1);
      check("busy_req_q_empty", exp_q.size(), 0);
      check("entry_cost_01", wr_cyc[1] - wr_cyc[0], PER_ENTRY);
      check("entry_cost_12", wr_cyc[2] - wr_cyc[1], PER_ENTRY);

      // DRDY timeout on the second read.
      gen++;
      drdy_dly = 2;
      drop_read = 2;
      push_writes(2'd0, 1);
      d0 = done_cnt;
      start(2'd0);
      n = 0;
      while (!err && n < 500) begin
         @(negedge clk);
         n++;
      end
      c_err = cyc;
      check("drdy_tmo_err", err, 1);
      check("drdy_tmo_cycles", c_err - rd_cyc[1], DRDY_TMO + 2);
      @(negedge clk);
      check("drdy_tmo_busy", busy, 0);
      check("drdy_tmo_rst", mmcm_rst, 0);
      check("drdy_tmo_err_sticky", err, 1);
      check("drdy_tmo_no_done", done_cnt - d0, 0);
      check("drdy_tmo_q_empty", exp_q.size(), 0);
      drop_read = 0;

      // Lock timeout: err exactly LOCK_TMO+1 cycles after LOCK_WAIT entry.
      gen++;
      lock_en = 1'b0;
      push_writes(2'd1, N_ENTRIES);
      d0 = done_cnt;
      start(2'd1);
      check("lock_err_cleared", err, 0);
      n = 0;
      prev = mmcm_rst;
      while (!(prev && !mmcm_rst) && n < 2000) begin
         prev = mmcm_rst;
         @(negedge clk);
         n++;
      end
      check("lock_release_seen", mmcm_rst, 0);
      n = 0;
      while (!err && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("lock_tmo_cycles", n, LOCK_TMO + 1);
      @(negedge clk);
      check("lock_tmo_busy", busy, 0);
      check("lock_tmo_no_done", done_cnt - d0, 0);
      lock_en = 1'b1;
      repeat (10) @(negedge clk);

      // srst during WR_WAIT of entry 1, then a clean restart.
      gen++;
      drdy_dly = 2;
      push_writes(2'd3, 2);
      start(2'd3);
      n = 0;
      while (!(drp_den && drp_dwe && tbl_idx == 2'd1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("srst_wr1_seen", drp_dwe, 1);
      @(negedge clk);
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      check_reset("srst");
      check("srst_q_empty", exp_q.size(), 0);
      repeat (10) @(negedge clk);
      gen++;
      push_writes(2'd3, N_ENTRIES);
      d0 = done_cnt;
      start(2'd3);
      check("restart_idx", tbl_idx, 0);
      wait_idle("restart_idle");
      check("restart_done", done_cnt - d0, 1);
      check("restart_q_empty", exp_q.size(), 0);

      // Read-back corrupted on entry 2.
      gen++;
      corrupt_en = 1'b1;
      corrupt_addr = entry_addr(2'd0, 2);
      push_writes(2'd0, N_ENTRIES);
      d0 = done_cnt;
      start(2'd0);
      wait_idle("vfy_idle");
`ifdef PLL_DRP_READBACK_EN
      check("vfy_err", err, 1);
      check("vfy_no_done", done_cnt - d0, 0);
`else
      check("vfy_err", err, 0);
      check("vfy_done", done_cnt - d0, 1);
`endif
      check("vfy_rst_off", mmcm_rst, 0);
      check("vfy_q_empty", exp_q.size(), 0);
      corrupt_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
